scroll_motion_ctrl: RTL and testbench

SCROLL_MOTION_CTRL -- requirements
Module: scroll_motion_ctrl

---
 rtl/scroll_motion_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_scroll_motion_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_motion_ctrl.sv
// Purpose: frame-divided scroll offset generator with per-axis bounce (or wrap with SCROLL_WRAP_EN).
// Latency: offsets/velocities/pulses update exactly 3 clocks after the edge that detects a counted vsync.
// Backpressure: none; frame starts arriving mid-update are dropped, velocity loads mid-update are held pending.
module scroll_motion_ctrl #(
    parameter int                 MAX_X      = 200,
    parameter int                 MAX_Y      = 150,
    parameter int                 FRAME_DIV  = 8,
    parameter logic signed [15:0] INIT_VEL_X = 16'sd2,
    parameter logic signed [15:0] INIT_VEL_Y = 16'sd1
) (
    input  logic               i_pix_clk,
    input  logic               i_reset_n,
    input  logic               i_vert_sync,
    input  logic               i_enable,
    input  logic               i_vel_load,
    input  logic signed [15:0] i_vel_x,
    input  logic signed [15:0] i_vel_y,
    output logic signed [15:0] o_offset_x,
    output logic signed [15:0] o_offset_y,
    output logic signed [15:0] o_vel_x,
    output logic signed [15:0] o_vel_y,
    output logic               o_frame_tick,
    output logic               o_bounce_x,
    output logic               o_bounce_y
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_CALC,
        ST_COMMIT
    } state_t;

    typedef struct packed {
        logic               hit;
        logic signed [15:0] vel;
        logic signed [15:0] off;
    } axis_t;

    localparam logic signed [16:0] MAX_X_S  = 17'(MAX_X);
    localparam logic signed [16:0] MAX_Y_S  = 17'(MAX_Y);
    localparam logic [7:0]         CNT_LAST = 8'(FRAME_DIV - 1);

    state_t             state;
    logic               vs_q;
    logic               sync_armed;
    logic               frame_start;
    logic [7:0]         frame_cnt;
    logic signed [16:0] next_x;
    logic signed [16:0] next_y;
    logic               pend_vld;
    logic signed [15:0] pend_x;
    logic signed [15:0] pend_y;
    axis_t              res_x;
    axis_t              res_y;

    // Resolve one axis against its bound: clamp and reflect, or wrap around.
    function automatic axis_t resolve(input logic signed [16:0] nxt,
                                      input logic signed [15:0] vel,
                                      input logic signed [16:0] max_v);
        axis_t r;
        r.hit = 1'b0;
        r.vel = vel;
        r.off = nxt[15:0];
`ifdef SCROLL_WRAP_EN
        if (nxt >= max_v) begin
            r.hit = 1'b1;
            r.off = 16'(nxt - max_v);
        end else if (nxt < 17'sd0) begin
            r.hit = 1'b1;
            r.off = 16'(nxt + max_v);
        end
`else
        if (nxt >= max_v) begin
            r.hit = 1'b1;
            r.off = 16'(max_v - 17'sd1);
            r.vel = -vel;
        end else if (nxt < 17'sd0) begin
            r.hit = 1'b1;
            r.off = '0;
            r.vel = -vel;
        end
`endif
        return r;
    endfunction

    // A vsync already high when reset releases must see a low level before it can count.
    assign frame_start = i_vert_sync & ~vs_q & sync_armed;

    // Bound handling for the sums captured in CALC, consumed in COMMIT.
    always_comb begin
        res_x = resolve(next_x, o_vel_x, MAX_X_S);
        res_y = resolve(next_y, o_vel_y, MAX_Y_S);
    end

    // Update sequencer: frame division, sum, commit, plus velocity load/pending handling.
    always_ff @(posedge i_pix_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= ST_IDLE;
            vs_q         <= 1'b0;
            sync_armed   <= 1'b0;
            frame_cnt    <= '0;
            next_x       <= '0;
            next_y       <= '0;
            pend_vld     <= 1'b0;
            pend_x       <= '0;
            pend_y       <= '0;
            o_offset_x   <= '0;
            o_offset_y   <= '0;
            o_vel_x      <= INIT_VEL_X;
            o_vel_y      <= INIT_VEL_Y;
            o_frame_tick <= 1'b0;
            o_bounce_x   <= 1'b0;
            o_bounce_y   <= 1'b0;
        end else begin
            vs_q         <= i_vert_sync;
            o_frame_tick <= 1'b0;
            o_bounce_x   <= 1'b0;
            o_bounce_y   <= 1'b0;
            if (!i_vert_sync) begin
                sync_armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_start && i_enable) begin
                        state <= ST_COUNT;
                    end
                    // A fresh strobe is newer than anything left pending from the last update.
                    if (i_vel_load) begin
                        o_vel_x  <= i_vel_x;
                        o_vel_y  <= i_vel_y;
                        pend_vld <= 1'b0;
                    end else if (pend_vld) begin
                        o_vel_x  <= pend_x;
                        o_vel_y  <= pend_y;
                        pend_vld <= 1'b0;
                    end
                end
                ST_COUNT: begin
                    if (i_vel_load) begin
                        o_vel_x <= i_vel_x;
                        o_vel_y <= i_vel_y;
                    end
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt <= '0;
                        state     <= ST_CALC;
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                        state     <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    next_x <= {o_offset_x[15], o_offset_x} + {o_vel_x[15], o_vel_x};
                    next_y <= {o_offset_y[15], o_offset_y} + {o_vel_y[15], o_vel_y};
                    if (i_vel_load) begin
                        pend_vld <= 1'b1;
                        pend_x   <= i_vel_x;
                        pend_y   <= i_vel_y;
                    end
                    state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    o_offset_x   <= res_x.off;
                    o_offset_y   <= res_y.off;
                    o_vel_x      <= res_x.vel;
                    o_vel_y      <= res_y.vel;
                    o_bounce_x   <= res_x.hit;
                    o_bounce_y   <= res_y.hit;
                    o_frame_tick <= 1'b1;
                    if (i_vel_load) begin
                        pend_vld <= 1'b1;
                        pend_x   <= i_vel_x;
                        pend_y   <= i_vel_y;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_motion_ctrl.sv
// Purpose: self-checking bench for scroll_motion_ctrl against an arithmetic reference model.
// Latency: expects commit results 3 clocks after the detecting edge.
// Backpressure: n/a (bench drives one vsync pulse at a time, 6 clocks apart).
module tb_scroll_motion_ctrl;

    localparam int MX = 200;
    localparam int MY = 150;
    localparam int FD = 8;

    logic               clk;
    logic               i_reset_n;
    logic               i_vert_sync;
    logic               i_enable;
    logic               i_vel_load;
    logic signed [15:0] i_vel_x;
    logic signed [15:0] i_vel_y;
    logic signed [15:0] o_offset_x;
    logic signed [15:0] o_offset_y;
    logic signed [15:0] o_vel_x;
    logic signed [15:0] o_vel_y;
    logic               o_frame_tick;
    logic               o_bounce_x;
    logic               o_bounce_y;

    int checks = 0;
    int errors = 0;

    // Reference model state: positions, velocities, counted frames since last update.
    int m_x, m_y, m_vx, m_vy, m_cnt;

    scroll_motion_ctrl #(
        .MAX_X(MX), .MAX_Y(MY), .FRAME_DIV(FD),
        .INIT_VEL_X(16'sd2), .INIT_VEL_Y(16'sd1)
    ) dut (
        .i_pix_clk   (clk),
        .i_reset_n   (i_reset_n),
        .i_vert_sync (i_vert_sync),
        .i_enable    (i_enable),
        .i_vel_load  (i_vel_load),
        .i_vel_x     (i_vel_x),
        .i_vel_y     (i_vel_y),
        .o_offset_x  (o_offset_x),
        .o_offset_y  (o_offset_y),
        .o_vel_x     (o_vel_x),
        .o_vel_y     (o_vel_y),
        .o_frame_tick(o_frame_tick),
        .o_bounce_x  (o_bounce_x),
        .o_bounce_y  (o_bounce_y)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 0; m_vx = 2; m_vy = 1; m_cnt = 0;
    endtask

    // One axis of a position update, straight from the bound rules.
    task automatic model_axis(inout int off, inout int vel, output bit hit, input int maxv);
        int nxt;
        nxt = off + vel;
        hit = 1'b0;
        if (nxt >= maxv) begin
            hit = 1'b1;
`ifdef SCROLL_WRAP_EN
            off = nxt - maxv;
`else
            off = maxv - 1;
            vel = -vel;
`endif
        end else if (nxt < 0) begin
            hit = 1'b1;
`ifdef SCROLL_WRAP_EN
            off = nxt + maxv;
`else
            off = 0;
            vel = -vel;
`endif
        end else begin
            off = nxt;
        end
    endtask

    task automatic chk_all(input string tag, input int tick, input int bx, input int by);
        chk({tag, "_tick"}, o_frame_tick, tick);
        chk({tag, "_bx"}, o_bounce_x, bx);
        chk({tag, "_by"}, o_bounce_y, by);
        chk({tag, "_offx"}, o_offset_x, m_x);
        chk({tag, "_offy"}, o_offset_y, m_y);
        chk({tag, "_velx"}, o_vel_x, m_vx);
        chk({tag, "_vely"}, o_vel_y, m_vy);
    endtask

    // One vsync pulse; optional velocity strobe in the third cycle and enable drop after detection.
    task automatic vs_pulse(input bit ld_calc, input int lx, input int ly, input bit en_drop);
        bit upd, ebx, eby;
        upd = 1'b0; ebx = 1'b0; eby = 1'b0;
        @(negedge clk);
        i_vert_sync = 1'b1;
        if (i_enable) begin
            m_cnt++;
            if (m_cnt == FD) begin
                m_cnt = 0;
                upd = 1'b1;
                model_axis(m_x, m_vx, ebx, MX);
                model_axis(m_y, m_vy, eby, MY);
            end
        end
        @(negedge clk);
        i_vert_sync = 1'b0;
        if (en_drop) i_enable = 1'b0;
        @(negedge clk);
        if (ld_calc) begin
            i_vel_load = 1'b1;
            i_vel_x    = 16'(lx);
            i_vel_y    = 16'(ly);
        end
        @(negedge clk);
        i_vel_load = 1'b0;
        chk("tick_early", o_frame_tick, 0);
        if (ld_calc && !upd) begin
            m_vx = lx; m_vy = ly;
        end
        @(negedge clk);
        chk_all("commit", upd, ebx, eby);
        @(negedge clk);
        if (ld_calc && upd) begin
            m_vx = lx; m_vy = ly;
        end
        chk("tick_width", o_frame_tick, 0);
        chk("after_velx", o_vel_x, m_vx);
        chk("after_vely", o_vel_y, m_vy);
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) vs_pulse(1'b0, 0, 0, 1'b0);
    endtask

    task automatic prep_last();
        while (m_cnt != FD - 1) vs_pulse(1'b0, 0, 0, 1'b0);
    endtask

    task automatic update();
        prep_last();
        vs_pulse(1'b0, 0, 0, 1'b0);
    endtask

    task automatic load_vel(input int vx, input int vy);
        @(negedge clk);
        i_vel_load = 1'b1;
        i_vel_x    = 16'(vx);
        i_vel_y    = 16'(vy);
        @(negedge clk);
        i_vel_load = 1'b0;
        m_vx = vx; m_vy = vy;
        chk("load_velx", o_vel_x, m_vx);
        chk("load_vely", o_vel_y, m_vy);
    endtask

    function automatic int rand_vel();
        return int'($urandom_range(0, 520)) - 260;
    endfunction

    initial begin
        clk = 1'b0;
        i_reset_n = 1'b0;
        i_vert_sync = 1'b0;
        i_enable = 1'b1;
        i_vel_load = 1'b0;
        i_vel_x = '0;
        i_vel_y = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all("reset", 0, 0, 0);
        i_reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Eight pulses from reset give exactly one commit at (2,1).
        frames(FD);
        chk("first_offx", o_offset_x, 2);
        chk("first_offy", o_offset_y, 1);

        // Right-edge hit from x=198 with vx=2.
        load_vel(196, 0);
        update();
        load_vel(2, 0);
        update();
`ifndef SCROLL_WRAP_EN
        chk("edge_offx", o_offset_x, 199);
        chk("edge_velx", o_vel_x, -2);
`else
        chk("edge_offx", o_offset_x, 0);
        chk("edge_velx", o_vel_x, 2);
`endif

        // Both axes cross zero in the same commit.
        load_vel(-198, -1);
        update();
        load_vel(-2, -1);
        update();
`ifndef SCROLL_WRAP_EN
        chk("corner_offx", o_offset_x, 0);
        chk("corner_offy", o_offset_y, 0);
        chk("corner_velx", o_vel_x, 2);
        chk("corner_vely", o_vel_y, 1);
`endif

        // Velocity strobe during CALC: commit uses old velocity, new one lands a clock later.
        prep_last();
        vs_pulse(1'b1, 5, -3, 1'b0);
        chk("pend_velx", o_vel_x, 5);
        chk("pend_vely", o_vel_y, -3);

        // Disabled for 20 pulses, then 8 enabled pulses give one update.
        i_enable = 1'b0;
        frames(20);
        i_enable = 1'b1;
        frames(FD);

        // Enable falling right after detection still completes the update.
        prep_last();
        vs_pulse(1'b0, 0, 0, 1'b1);
        frames(3);
        i_enable = 1'b1;
        update();

        // Reset while in CALC, releasing with vsync held high.
        prep_last();
        @(negedge clk);
        i_vert_sync = 1'b1;
        @(negedge clk);
        i_vert_sync = 1'b0;
        @(negedge clk);
        i_vert_sync = 1'b1;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst", 0, 0, 0);
        @(negedge clk);
        chk_all("rst_held", 0, 0, 0);
        i_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rel_tick", o_frame_tick, 0);
        end
        i_vert_sync = 1'b0;
        frames(FD);
        chk("rel_offx", o_offset_x, 2);
        chk("rel_offy", o_offset_y, 1);

        // Randomized updates with random loads, enable gaps and mid-update strobes.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 1) load_vel(rand_vel(), rand_vel());
            if ($urandom_range(0, 3) == 0) begin
                i_enable = 1'b0;
                frames(int'($urandom_range(1, 5)));
                i_enable = 1'b1;
            end
            prep_last();
            vs_pulse(1'($urandom_range(0, 1)), rand_vel(), rand_vel(),
                     1'($urandom_range(0, 3) == 0));
            i_enable = 1'b1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
